dx_sram_responder: RTL

- Responder end of the DX memory bus. It services DX transactions from an initiator such as the line cache: single, incrementing and wrapping bursts, reads and writes.
- Backed by an internal word-addressed SRAM array that decodes one address window.
- Sits on the memory side of the MMU fabric, one instance per memory region.

---
 rtl/dx_sram_responder.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/dx_sram_responder.sv
// DX bus responder backed by a word-addressed SRAM covering one address window.
// Define DX_WAIT_STATE_EN to stall WAIT_CYCLES cycles before every beat and add DX_BEAT_VALID.
module dx_sram_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          INCR_BEATS  = 8,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        DX_CLAIM,
  input  logic [31:0] DX_ADDR,
  input  logic        DX_WRITE,
  input  logic [2:0]  DX_SIZE,
  input  logic [2:0]  DX_BURST,
  input  logic [31:0] DX_WRITE_DATA,
  output logic [31:0] DX_READ_DATA,
  output logic        DX_READYOUT,
  output logic        DX_RESP,
  output logic        DX_TRANSFER_COMPLETE
`ifdef DX_WAIT_STATE_EN
  ,
  output logic        DX_BEAT_VALID
`endif
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    ERR1,
    ERR2
`ifdef DX_WAIT_STATE_EN
    ,
    WAIT
`endif
  } state_t;

  state_t      state;
  logic        ready;
  logic        resp;
  logic [31:0] addr;
  logic        write;
  logic [1:0]  size;
  logic [2:0]  burst;
  logic [7:0]  beat_cnt;
  logic [7:0]  last_idx;
  logic [31:0] rd_data;
  logic [31:0] mem [DEPTH_WORDS];

  logic          req_err;
  logic          beat;
  logic          cur_last;
  logic          nxt_ok;
  logic          we;
  logic          re;
  logic [31:0]   nxt;
  logic [3:0]    be;
  logic [AW-1:0] ridx;

`ifdef DX_WAIT_STATE_EN
  localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [WCW-1:0] wait_cnt;
`endif

  function automatic logic in_window(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < WIN_END);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  function automatic logic burst_legal(input logic [2:0] b);
    return (b == 3'd0) || (b == 3'd1) || (b == 3'd2) || (b == 3'd3) || (b == 3'd5) || (b == 3'd7);
  endfunction

  function automatic logic [7:0] beat_total(input logic [2:0] b);
    case (b)
      3'd1:       return 8'(INCR_BEATS);
      3'd2, 3'd3: return 8'd4;
      3'd5:       return 8'd8;
      3'd7:       return 8'd16;
      default:    return 8'd1;
    endcase
  endfunction

  // WRAP4 keeps the bits above a 4-beat block and wraps the offset within it.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] s, input logic wrap);
    logic [31:0] step;
    logic [31:0] mask;
    step = 32'd1 << s;
    mask = (32'd4 << s) - 32'd1;
    if (wrap) return (a & ~mask) | ((a + step) & mask);
    return a + step;
  endfunction

  always_comb begin
    req_err  = (DX_SIZE > 3'd2) || !burst_legal(DX_BURST) || !in_window(DX_ADDR)
               || (DX_SIZE == 3'd1 && DX_ADDR[0]) || (DX_SIZE == 3'd2 && DX_ADDR[1:0] != 2'b00);
    nxt      = next_addr(addr, size, burst == 3'd2);
    nxt_ok   = in_window(nxt);
    cur_last = (beat_cnt == last_idx);
    beat     = (state == DATA) && DX_CLAIM;
    we       = beat && write;
    case (size)
      2'd0:    be = 4'b0001 << addr[1:0];
      2'd1:    be = 4'b0011 << addr[1:0];
      default: be = 4'b1111;
    endcase
`ifdef DX_WAIT_STATE_EN
    re   = (state == WAIT) && !write;
    ridx = word_idx(addr);
`else
    // Reads are prefetched one edge ahead so each beat's data is valid in its own cycle.
    re   = ((state == IDLE) && DX_CLAIM && !DX_WRITE && !req_err)
           || (beat && !write && !cur_last && nxt_ok);
    ridx = (state == IDLE) ? word_idx(DX_ADDR) : word_idx(nxt);
`endif
  end

  // A transfer is either all reads or all writes, so a read and write never share an edge.
  always_ff @(posedge CLK) begin
    if (RSTN && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx(addr)][8*i +: 8] <= DX_WRITE_DATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN)   rd_data <= '0;
    else if (re) rd_data <= mem[ridx];
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state    <= IDLE;
      ready    <= 1'b1;
      resp     <= 1'b0;
      addr     <= '0;
      write    <= 1'b0;
      size     <= '0;
      burst    <= '0;
      beat_cnt <= '0;
      last_idx <= '0;
`ifdef DX_WAIT_STATE_EN
      wait_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (DX_CLAIM) begin
            addr     <= DX_ADDR;
            write    <= DX_WRITE;
            size     <= DX_SIZE[1:0];
            burst    <= DX_BURST;
            beat_cnt <= '0;
            last_idx <= beat_total(DX_BURST) - 8'd1;
            ready    <= 1'b0;
            if (req_err) begin
              state <= ERR1;
              resp  <= 1'b1;
            end else begin
`ifdef DX_WAIT_STATE_EN
              state    <= WAIT;
              wait_cnt <= '0;
`else
              state    <= DATA;
`endif
            end
          end
        end
        DATA: begin
          if (!DX_CLAIM || cur_last) begin
            state <= IDLE;
            ready <= 1'b1;
          end else if (!nxt_ok) begin
            state <= ERR1;
            resp  <= 1'b1;
          end else begin
            addr     <= nxt;
            beat_cnt <= beat_cnt + 8'd1;
`ifdef DX_WAIT_STATE_EN
            state    <= WAIT;
            wait_cnt <= '0;
`endif
          end
        end
`ifdef DX_WAIT_STATE_EN
        WAIT: begin
          if (!DX_CLAIM) begin
            state <= IDLE;
            ready <= 1'b1;
          end else if (wait_cnt == WCW'(WAIT_CYCLES - 1)) begin
            state <= DATA;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
`endif
        ERR1: begin
          state <= ERR2;
          ready <= 1'b1;
        end
        ERR2: begin
          state <= IDLE;
          resp  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          resp  <= 1'b0;
        end
      endcase
    end
  end

  assign DX_READ_DATA         = rd_data;
  assign DX_READYOUT          = ready;
  assign DX_RESP              = resp;
  assign DX_TRANSFER_COMPLETE = (state == ERR2) || (beat && cur_last);
`ifdef DX_WAIT_STATE_EN
  assign DX_BEAT_VALID        = (state == DATA);
`endif

endmodule
